// File: rtl/plot_pkg.sv
// Shared types and constants for the pixel-plot sink: screen geometry, pixel record, FSM encoding.
package plot_pkg;

    localparam int unsigned SCREEN_W  = 160;
    localparam int unsigned SCREEN_H  = 120;
    localparam int unsigned FB_ADDR_W = 15;
    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned COORD_W   = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        StDrain = 1'b0,
        StClear = 1'b1
    } state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of pixel records; storage and pointers clear on asynchronous reset.
module pixel_fifo
    import plot_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  pixel_t                 wdata_i,
    input  logic                   pop_i,
    output pixel_t                 rdata_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    pixel_t          mem_q [Depth];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW + 1)'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/pixel_plot_sink.sv
// Buffers game pixel plots and drains them into the framebuffer write port; also sweeps a
// full-screen clear that takes priority over draining.
module pixel_plot_sink
    import plot_pkg::*;
#(
    parameter int unsigned        FIFO_DEPTH = 8,
    parameter int unsigned        SCREEN_W   = 160,
    parameter int unsigned        SCREEN_H   = 120,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 plot,
    input  logic [7:0]           x,
    input  logic [7:0]           y,
    input  logic [2:0]           color,
    input  logic                 clear_req,
    input  logic                 fb_ready,
    output logic                 fb_we,
    output logic [14:0]          fb_addr,
    output logic [2:0]           fb_data,
    output logic                 clear_busy,
    output logic                 overflow,
    output logic                 oob
);

    localparam int unsigned          CntW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COORD_W-1:0]   XLim      = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0]   YLim      = COORD_W'(SCREEN_H);
    localparam logic [FB_ADDR_W-1:0] RowStride = FB_ADDR_W'(SCREEN_W);
    localparam logic [FB_ADDR_W-1:0] ClearLast = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

    state_e                state_q, state_d;
    logic [FB_ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic                  overflow_q, oob_q;

    pixel_t                in_px, head_px;
    logic [CntW-1:0]       fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  in_range, push, pop;
    logic [FB_ADDR_W-1:0]  head_addr;

    always_comb begin
        in_px       = '0;
        in_px.x     = x;
        in_px.y     = y;
        in_px.color = color;
    end

    // Room is judged on the pre-edge occupancy, so a same-cycle pop never frees a slot.
    assign in_range = (x < XLim) && (y < YLim);
    assign push     = plot && in_range && (fifo_count < CntW'(FIFO_DEPTH));

    pixel_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (in_px),
        .pop_i   (pop),
        .rdata_o (head_px),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_addr = FB_ADDR_W'(head_px.y) * RowStride + FB_ADDR_W'(head_px.x);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        fb_we     = 1'b0;
        pop       = 1'b0;
        fb_addr   = head_addr;
        fb_data   = head_px.color;
        unique case (state_q)
            StDrain: begin
                fb_we = fb_ready && !fifo_empty;
                pop   = fb_we;
                if (clear_req) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            StClear: begin
                fb_we   = fb_ready;
                fb_addr = clr_cnt_q;
                fb_data = BG_COLOR;
                if (fb_ready) begin
                    if (clr_cnt_q == ClearLast) begin
                        state_d   = StDrain;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StDrain;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StDrain;
            clr_cnt_q  <= '0;
            overflow_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            overflow_q <= overflow_q | (plot && in_range && fifo_full);
            oob_q      <= oob_q | (plot && !in_range);
        end
    end

    assign clear_busy = (state_q == StClear);
    assign overflow   = overflow_q;
    assign oob        = oob_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: expected framebuffer writes are queued as stimulus is
// driven and matched against every fb_we cycle observed on the falling edge.
module tb_pixel_plot_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        plot;
    logic [7:0]  x, y;
    logic [2:0]  color;
    logic        clear_req;
    logic        fb_ready;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        clear_busy, overflow, oob;

    int          checks   = 0;
    int          failures = 0;
    logic [17:0] sb[$];

    pixel_plot_sink #(
        .FIFO_DEPTH (8),
        .SCREEN_W   (160),
        .SCREEN_H   (120),
        .BG_COLOR   (3'b000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .color      (color),
        .clear_req  (clear_req),
        .fb_ready   (fb_ready),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .clear_busy (clear_busy),
        .overflow   (overflow),
        .oob        (oob)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int addr, input logic [2:0] data);
        sb.push_back({addr[14:0], data});
    endtask

    // Every write the DUT makes must be the next expected one, in order.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(fb_we), 32'd0);
            end else begin
                chk("fb_write", 32'({fb_addr, fb_data}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(fb_we), 0);
        chk({tag, "_addr"}, 32'(fb_addr), 0);
        chk({tag, "_data"}, 32'(fb_data), 0);
        chk({tag, "_busy"}, 32'(clear_busy), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_oob"}, 32'(oob), 0);
    endtask

    initial begin
        int n, busy_cyc, stalls;
        reset = 1'b1; plot = 1'b0; x = '0; y = '0; color = '0;
        clear_req = 1'b0; fb_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Single plot: (5,3) -> 3*160+5 = 485, written the cycle after sampling.
        fb_ready = 1'b1;
        plot = 1'b1; x = 8'd5; y = 8'd3; color = 3'b100;
        expect_wr(485, 3'b100);
        tick();
        plot = 1'b0;
        chk("single_we", 32'(fb_we), 1);
        chk("single_addr", 32'(fb_addr), 485);
        tick();
        chk("single_we_low", 32'(fb_we), 0);

        // Bottom-right corner.
        plot = 1'b1; x = 8'd159; y = 8'd119; color = 3'b111;
        expect_wr(19199, 3'b111);
        tick();
        plot = 1'b0;
        tick();

        // Off-screen plots are dropped.
        plot = 1'b1; x = 8'd160; y = 8'd0; color = 3'b001;
        tick();
        x = 8'd0; y = 8'd120;
        tick();
        plot = 1'b0;
        tick();
        chk("oob_set", 32'(oob), 1);
        chk("oob_no_ovf", 32'(overflow), 0);
        chk("oob_no_write", 32'(fb_we), 0);

        // Backpressure: nine plots into an eight-deep FIFO.
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            plot = 1'b1; x = 8'(i); y = 8'd0; color = 3'(i);
            if (i < 8) expect_wr(i, 3'(i));
            tick();
        end
        plot = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_stalled", 32'(fb_we), 0);
        fb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_back_to_back", 32'(fb_we), 1);
            tick();
        end
        chk("drain_done", 32'(fb_we), 0);
        chk("drain_sb_empty", 32'(sb.size()), 0);

        // Full clear with a stalling grant, a plot at cycle 100 and an ignored re-request.
        clear_req = 1'b1;
        for (int a = 0; a < 19200; a++) expect_wr(a, 3'b000);
        tick();
        clear_req = 1'b0;
        chk("clear_busy_rise", 32'(clear_busy), 1);
        n = 0; busy_cyc = 0; stalls = 0;
        while (clear_busy && n < 40000) begin
            fb_ready  = (n < 300) ? ((n % 3) != 0) : 1'b1;
            plot      = (n == 100);
            x = 8'd10; y = 8'd0; color = 3'b101;
            clear_req = (n == 250);
            if (n == 100) expect_wr(10, 3'b101);
            busy_cyc++;
            if (!fb_ready) stalls++;
            tick();
            plot = 1'b0; clear_req = 1'b0;
            n++;
        end
        fb_ready = 1'b1;
        chk("clear_finished", 32'(clear_busy), 0);
        chk("clear_duration", 32'(busy_cyc), 32'(19200 + stalls));
        tick();
        tick();
        chk("post_clear_sb_empty", 32'(sb.size()), 0);

        // Reset while the clear is at address 5000.
        clear_req = 1'b1;
        for (int a = 0; a < 19200; a++) expect_wr(a, 3'b000);
        tick();
        clear_req = 1'b0;
        n = 0;
        while (fb_addr !== 15'd5000 && n < 10000) begin
            tick();
            n++;
        end
        chk("reached_5000", 32'(fb_addr), 5000);
        reset = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs("mid_reset");
        tick();
        reset = 1'b0;
        tick();
        plot = 1'b1; x = 8'd20; y = 8'd2; color = 3'b110;
        expect_wr(340, 3'b110);
        tick();
        plot = 1'b0;
        repeat (20) tick();
        chk("after_reset_busy", 32'(clear_busy), 0);
        chk("after_reset_sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
